// File: rtl/accel_pkg.sv
// -----------------------------------------------------------------------------
// accel_pkg
//   Shared constants and types for the accelerator output path. The controller,
//   the output-buffer wrapper and output_drain all import this package so the
//   output-buffer geometry is defined in exactly one place.
//   OB_AW         : output-buffer word-address width
//   ACC_DW        : accelerator data word width
//   drain_state_t : output_drain FSM encoding
// -----------------------------------------------------------------------------
package accel_pkg;

    localparam int unsigned OB_AW  = 17;
    localparam int unsigned ACC_DW = 512;

    // Prefixed literals: the bare name DONE is also a port of output_drain.
    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_RUN  = 2'd1,
        DRAIN_DONE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/drain_skid_fifo.sv
// -----------------------------------------------------------------------------
// drain_skid_fifo
//   Small synchronous FIFO that absorbs SRAM read latency and consumer
//   back-pressure for output_drain. The head word is taken straight from the
//   storage flops, so it is registered and holds steady until popped.
//   clk       in   clock (posedge)
//   rst_n     in   asynchronous active-low reset; empties the FIFO, clears storage
//   push      in   write push_data this cycle (caller guarantees not full)
//   push_data in   DW-bit word to store
//   pop       in   drop the head word this cycle (caller guarantees not empty)
//   count     out  number of stored words
//   head      out  oldest stored word
// -----------------------------------------------------------------------------
module drain_skid_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned DW    = 512,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/output_drain.sv
// -----------------------------------------------------------------------------
// output_drain
//   Reads LEN consecutive words from the output-buffer SRAM starting at
//   BASE_ADDR and streams them out over valid/ready. Owns the SRAM port while
//   BUSY. A credit check on FIFO occupancy plus the read in flight keeps the
//   skid FIFO from overflowing under back-pressure.
//   CLK        in   clock (posedge)
//   RESET      in   asynchronous active-low reset
//   START      in   1-cycle start pulse, honoured only when idle
//   BASE_ADDR  in   first word address (sampled with START)
//   LEN        in   words to drain (sampled with START)
//   BUSY       out  drain in progress, through the DONE cycle
//   DONE       out  1-cycle completion pulse
//   OB_REQ     out  output-buffer port request (= BUSY)
//   OB_CEN     out  SRAM chip enable, active-low
//   OB_WEN     out  SRAM write enable, active-low, tied inactive
//   OB_RETN    out  SRAM retention, tied high
//   OB_A       out  SRAM word address
//   OB_Q       in   SRAM read data, one cycle after OB_CEN low
//   OUT_VALID  out  stream valid
//   OUT_READY  in   stream ready
//   OUT_DATA   out  stream data
//   OUT_LAST   out  marks the final word of the drain
// -----------------------------------------------------------------------------
module output_drain
    import accel_pkg::*;
#(
    parameter int unsigned AW         = OB_AW,
    parameter int unsigned DW         = ACC_DW,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic [AW-1:0] BASE_ADDR,
    input  logic [AW-1:0] LEN,
    output logic          BUSY,
    output logic          DONE,
    output logic          OB_REQ,
    output logic          OB_CEN,
    output logic          OB_WEN,
    output logic          OB_RETN,
    output logic [AW-1:0] OB_A,
    input  logic [DW-1:0] OB_Q,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic          OUT_LAST
);

    localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    drain_state_t  state;
    logic [AW-1:0] base_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] issued;
    logic [AW-1:0] sent;
    logic          inflight;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credit_used;
    logic          issue;
    logic          pop;
    logic          last_word;

    assign pop       = OUT_VALID & OUT_READY;
    assign last_word = (sent == len_q - AW'(1));

    // Slots committed for next cycle: stored words, plus the read now landing,
    // minus the word leaving. pop implies fifo_cnt >= 1, so this never wraps.
    always_comb begin
        credit_used = {1'b0, fifo_cnt} + (CW + 1)'(inflight) - (CW + 1)'(pop);
        issue       = (state == DRAIN_RUN) && (issued < len_q) && (credit_used < DEPTH_C);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= DRAIN_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                DRAIN_IDLE: begin
                    if (START) begin
                        base_q <= BASE_ADDR;
                        len_q  <= LEN;
                        issued <= '0;
                        sent   <= '0;
                        state  <= (LEN != '0) ? DRAIN_RUN : DRAIN_DONE;
                    end
                end
                DRAIN_RUN: begin
                    if (issue) begin
                        issued <= issued + AW'(1);
                    end
                    if (pop) begin
                        sent <= sent + AW'(1);
                        if (last_word) begin
                            state <= DRAIN_DONE;
                        end
                    end
                end
                DRAIN_DONE: begin
                    state <= DRAIN_IDLE;
                end
                default: begin
                    state <= DRAIN_IDLE;
                end
            endcase
        end
    end

    drain_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (inflight),
        .push_data (OB_Q),
        .pop       (pop),
        .count     (fifo_cnt),
        .head      (OUT_DATA)
    );

    assign BUSY      = (state != DRAIN_IDLE);
    assign DONE      = (state == DRAIN_DONE);
    assign OB_REQ    = BUSY;
    assign OB_CEN    = ~issue;
    assign OB_WEN    = 1'b1;
    assign OB_RETN   = 1'b1;
    assign OB_A      = base_q + issued;
    assign OUT_VALID = (fifo_cnt != '0);
    assign OUT_LAST  = OUT_VALID & last_word;

endmodule

// File: tb/tb_output_drain.sv
// -----------------------------------------------------------------------------
// tb_output_drain
//   Self-checking bench for output_drain: a table of drain requests with
//   expected latencies, an address-derived SRAM model, and hand-written
//   sequences for reset mid-drain.
// -----------------------------------------------------------------------------
module tb_output_drain;

    localparam int unsigned AW = 17;
    localparam int unsigned DW = 512;
    localparam int          FD = 2;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          START = 1'b0;
    logic [AW-1:0] BASE_ADDR = '0;
    logic [AW-1:0] LEN = '0;
    logic          BUSY, DONE, OB_REQ, OB_CEN, OB_WEN, OB_RETN;
    logic [AW-1:0] OB_A;
    logic [DW-1:0] OB_Q = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b1;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_LAST;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        int            mode;       // 0: ready held high, 1: ready random
        int            poke;       // run cycle to pulse a stray START, -1 none
        int            exp_first;  // expected first OUT_VALID run cycle, -1 skip
    } vec_t;

    output_drain #(
        .AW         (AW),
        .DW         (DW),
        .FIFO_DEPTH (FD)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .BASE_ADDR (BASE_ADDR),
        .LEN       (LEN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .OB_REQ    (OB_REQ),
        .OB_CEN    (OB_CEN),
        .OB_WEN    (OB_WEN),
        .OB_RETN   (OB_RETN),
        .OB_A      (OB_A),
        .OB_Q      (OB_Q),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_LAST  (OUT_LAST)
    );

    always #5 CLK = ~CLK;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*32 +: 32] = {15'(i), a} ^ 32'hC3A5_0F1E;
        end
        return r;
    endfunction

    // SRAM model: one-cycle read latency.
    always @(posedge CLK) begin
        if (!OB_CEN) OB_Q <= word_of(OB_A);
    end

    function automatic void check_i(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void check_w(input string name, input logic [DW-1:0] act,
                                     input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic check_reset(input string tag);
        check_i({tag, "_busy"},   int'(BUSY),      0);
        check_i({tag, "_done"},   int'(DONE),      0);
        check_i({tag, "_obreq"},  int'(OB_REQ),    0);
        check_i({tag, "_valid"},  int'(OUT_VALID), 0);
        check_i({tag, "_last"},   int'(OUT_LAST),  0);
        check_i({tag, "_cen"},    int'(OB_CEN),    1);
        check_i({tag, "_wen"},    int'(OB_WEN),    1);
        check_i({tag, "_retn"},   int'(OB_RETN),   1);
        check_i({tag, "_addr"},   int'(OB_A),      0);
        check_w({tag, "_data"},   OUT_DATA,        '0);
    endtask

    task automatic drain(input vec_t v);
        int            n_iss = 0;
        int            n_sent = 0;
        int            n_vcyc = 0;
        int            first_v = -1;
        int            last_hs = -1;
        int            done_c = -1;
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [AW-1:0] exp_a;
        logic          pop;

        @(posedge CLK); #1;
        START = 1'b1; BASE_ADDR = v.base; LEN = v.len; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        // Scramble the request inputs so only the latched copy can be used.
        START = 1'b0; BASE_ADDR = 17'h1ABCD; LEN = 17'd5;
        for (int cyc = 0; cyc < 300; cyc++) begin
            OUT_READY = (v.mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cyc == v.poke) begin
                START = 1'b1; BASE_ADDR = 17'h07777; LEN = 17'd9;
            end else begin
                START = 1'b0;
            end
            #1;
            check_i("busy",  int'(BUSY),   1);
            check_i("obreq", int'(OB_REQ), 1);
            check_i("wen",   int'(OB_WEN), 1);
            check_i("retn",  int'(OB_RETN), 1);
            pop = OUT_VALID & OUT_READY;
            if (!OB_CEN) begin
                exp_a = v.base + AW'(n_iss);
                check_i("ob_a", int'(OB_A), int'(exp_a));
                check_i("credit", int'((n_iss - n_sent - (pop ? 1 : 0)) < FD), 1);
                if (v.mode == 0) check_i("issue_cycle", cyc, n_iss);
                n_iss++;
            end
            if (OUT_VALID) begin
                n_vcyc++;
                if (first_v < 0) first_v = cyc;
                exp_a = v.base + AW'(n_sent);
                check_w("out_data", OUT_DATA, word_of(exp_a));
                check_i("out_last", int'(OUT_LAST), int'(n_sent == int'(v.len) - 1));
                if (prev_stall) check_w("stall_hold", OUT_DATA, prev_data);
            end else if (prev_stall) begin
                check_i("stall_valid", int'(OUT_VALID), 1);
            end
            prev_stall = OUT_VALID & ~OUT_READY;
            prev_data  = OUT_DATA;
            if (pop) begin
                n_sent++;
                last_hs = cyc;
            end
            if (DONE) begin
                done_c = cyc;
                break;
            end
            @(posedge CLK); #1;
        end
        START = 1'b0;
        check_i("done_seen", int'(done_c >= 0), 1);
        check_i("n_issued",  n_iss,  int'(v.len));
        check_i("n_sent",    n_sent, int'(v.len));
        if (v.mode == 0) check_i("valid_cycles", n_vcyc, int'(v.len));
        if (v.len == '0) check_i("done_lat", done_c, 0);
        else             check_i("done_lat", done_c, last_hs + 1);
        if (v.exp_first >= 0) check_i("first_valid", first_v, v.exp_first);
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        check_i("post_busy",  int'(BUSY),      0);
        check_i("post_done",  int'(DONE),      0);
        check_i("post_valid", int'(OUT_VALID), 0);
        repeat (3) begin
            @(posedge CLK); #1;
            check_i("idle_cen",  int'(OB_CEN), 1);
            check_i("idle_busy", int'(BUSY),   0);
        end
    endtask

    initial begin
        vec_t vecs[6];
        int   hs;

        #2 RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset("por");
        RESET = 1'b1;

        vecs[0] = '{17'h00010, 17'd4, 0, -1,  2};
        vecs[1] = '{17'h1FFFE, 17'd3, 0, -1,  2};
        vecs[2] = '{17'h00100, 17'd8, 1, -1, -1};
        vecs[3] = '{17'h00055, 17'd0, 0, -1, -1};
        vecs[4] = '{17'h00300, 17'd5, 0,  2,  2};
        vecs[5] = '{17'h00020, 17'd1, 0, -1,  2};
        for (int k = 0; k < 6; k++) begin
            drain(vecs[k]);
        end

        // Reset in the middle of a 6-word drain, after two handshakes.
        @(posedge CLK); #1;
        START = 1'b1; BASE_ADDR = 17'h00200; LEN = 17'd6; OUT_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        hs = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (OUT_VALID && OUT_READY) hs++;
            @(posedge CLK); #1;
        end
        check_i("hs_before_reset",   hs,         2);
        check_i("busy_before_reset", int'(BUSY), 1);
        RESET = 1'b0;
        #1;
        check_reset("mid");
        @(posedge CLK); #1;
        RESET = 1'b1;
        repeat (4) begin
            @(posedge CLK); #1;
            check_i("after_rst_done", int'(DONE),   0);
            check_i("after_rst_busy", int'(BUSY),   0);
            check_i("after_rst_cen",  int'(OB_CEN), 1);
        end
        drain('{17'h00000, 17'd2, 0, -1, 2});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
